seven_segment_bank: RTL and testbench
=====================================

Name: seven_segment_bank

Overview:
Parametrised multi-digit seven-segment display driver for the DE2 HEX displays. It accepts a binary value on a load strobe and converts it to decimal or hex digits; decimal conversion is a sequential double-dabble, one bit per clock. Outputs are registered glyphs with overflow indication, leading-zero blanking and per-digit blink. The previous value stays on the display until the new conversion commits, so the display never shows a partial result.

Parameters:
DIGITS, 4, number of displayed digits (1..8)
BIN_W, 14, width of binary input; must satisfy BIN_W <= 4*DIGITS
ACTIVE_LOW, 1, 1 = segment on is driven 0 (DE2); 0 = segment on is driven 1
BLINK_DIV, 25000000, clock cycles per blink half-period (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
load  in  1  start conversion of value; sampled only in IDLE
value  in  BIN_W  binary value to display
hex_mode  in  1  0 = decimal, 1 = hexadecimal; sampled with load
blank_lz  in  1  1 = blank leading zero digits (live, not sampled)
blink_en  in  DIGITS  per-digit blink enable (live)
seg  out  7*DIGITS  glyphs; seg[7i+6:7i] = digit i, digit 0 least significant; bit order a,b,c,d,e,f,g (bit 6 = a)
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when the display registers commit
overflow  out  1  last committed decimal value was >= 10^DIGITS

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - state goes to IDLE; digit registers become 0; overflow=0, busy=0, done=0.
  - Blink counter is cleared and the blink phase is set to ON.
  - seg shows "0" on every digit, or "0" on digit 0 only when blank_lz=1.
- FSM states are IDLE, SHIFT and COMMIT.
  - IDLE with load=1 at edge N: capture value and hex_mode; busy=1 after edge N.
  - Decimal: go to SHIFT with bit count BIN_W.
  - Hex: go straight to COMMIT.
- SHIFT: one double-dabble step per edge.
  - Add 3 to each BCD nibble >= 5, then shift the MSB of the binary register into the BCD LSB.
  - If a 1 is shifted out of the top nibble (digit DIGITS-1), set the sticky internal ovf flag.
  - After BIN_W steps, go to COMMIT.
- COMMIT: copy the BCD (or hex nibbles) into the display digit registers, overflow <= ovf (hex: 0), done=1 for this cycle only, busy=0 after this edge, return to IDLE.
- Latency:
  - Decimal: commit at edge N+BIN_W+1; seg reflects it after edge N+BIN_W+2.
  - Hex: commit at edge N+1; seg after edge N+2.
- load while busy is ignored and not queued. load in the COMMIT cycle is also ignored. A new conversion is accepted from the cycle after done.
- Glyphs:
  - 0-9 use the standard patterns (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011).
  - Hex A-F: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Dash = 0000001; blank = 0000000.
  - When ACTIVE_LOW=1, invert the whole pattern at the output register.
- Display priority per digit, highest first:
  1. overflow=1 → dash on all digits.
  2. blink_en[i]=1 and blink phase OFF → blank.
  3. blank_lz=1, digit i>0 and all digits i..DIGITS-1 are zero → blank.
  4. Otherwise the digit glyph.
- Digit 0 is never lead-blanked.
- blank_lz and blink_en are live; a change appears on seg one cycle later.
- Blink counter counts 0..BLINK_DIV-1 and toggles the phase on wrap. It free-runs independently of conversions.
- Reset mid-SHIFT aborts the conversion: the previous display is discarded and the reset values above apply; done does not pulse.

Test Plan:
- Decimal load: DIGITS=4, BIN_W=14, value=1234, hex_mode=0, load at edge N → busy over N+1..N+15; done high in the cycle following edge N+15; after edge N+16 seg = {4F,12,06,4C} (digit3..0, active-low hex); overflow=0.
- Hex load: value=0x2BEF, hex_mode=1 → done one cycle after load; seg = {12,60,30,38}; seg reflects it two edges after load.
- Overflow: value=10000 decimal → overflow=1, all digits 7E. Then load 9999 → overflow=0, all digits glyph 9 (04).
- Leading-zero blanking: value=7, blank_lz=1 → {7F,7F,7F,0F}. value=0, blank_lz=1 → {7F,7F,7F,01}. Toggle blank_lz to 0 → {01,01,01,0F} (value 7) one cycle later.
- Blink: BLINK_DIV=4, blink_en=4'b0001, value=1234 → digit 0 alternates 4C / 7F every 4 cycles; other digits stay constant.
- Robustness: load pulse during SHIFT → ignored, result is still the first value. rst asserted mid-SHIFT → next cycle busy=0, seg all 01, no done pulse.

Source files
------------

// File: rtl/seven_segment_bank.sv
// Multi-digit seven-segment driver: binary value -> decimal (serial double-dabble) or hex digits,
// with registered glyphs, overflow dashes, leading-zero blanking and per-digit blink.
module seven_segment_bank #(
    parameter int DIGITS     = 4,
    parameter int BIN_W      = 14,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state, state_nx;
    logic [BIN_W-1:0] bin_r;
    logic [NW-1:0]   bcd_r, bcd_adj, bcd_nx, disp;
    logic [CW-1:0]   cnt;
    logic            ovf, hex_r, carry;
    logic [BW-1:0]   blink_cnt;
    logic            blink_on;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = hex_mode ? COMMIT : SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // One double-dabble step: correct nibbles >= 5, then shift the binary MSB into the BCD LSB.
    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
        bcd_nx = {bcd_adj[NW-2:0], bin_r[BIN_W-1]};
        carry  = bcd_adj[NW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r    <= '0;
            bcd_r    <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            hex_r    <= 1'b0;
            disp     <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    bin_r <= value;
                    hex_r <= hex_mode;
                    bcd_r <= '0;
                    ovf   <= 1'b0;
                    cnt   <= CW'(BIN_W);
                end
                SHIFT: begin
                    bcd_r <= bcd_nx;
                    bin_r <= bin_r << 1;
                    ovf   <= ovf | carry;
                    cnt   <= cnt - CW'(1);
                end
                COMMIT: begin
                    disp     <= hex_r ? NW'(bin_r) : bcd_r;
                    overflow <= hex_r ? 1'b0 : ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Render from reset values while rst is high so seg is valid right after the reset edge.
    logic [NW-1:0]        disp_src;
    logic                 ovf_src, phase_src, lz_run;
    logic [3:0]           nib;
    logic [6:0]           pat;
    logic [7*DIGITS-1:0]  seg_nx;

    always_comb begin
        disp_src  = rst ? '0 : disp;
        ovf_src   = rst ? 1'b0 : overflow;
        phase_src = rst ? 1'b1 : blink_on;
        seg_nx    = '0;
        lz_run    = 1'b1;
        nib       = '0;
        pat       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib    = disp_src[4*i +: 4];
            lz_run = lz_run & (nib == 4'd0);
            pat    = glyph(nib);
            if (ovf_src)                          pat = 7'b0000001;
            else if (blink_en[i] && !phase_src)   pat = 7'b0000000;
            else if (blank_lz && i > 0 && lz_run) pat = 7'b0000000;
            seg_nx[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

    always_ff @(posedge clk) begin
        seg <= seg_nx;
    end

endmodule

// File: tb/tb_seven_segment_bank.sv
// Self-checking bench for seven_segment_bank: directed plan vectors plus randomized loads
// compared against an arithmetic digit/glyph model.
module tb_seven_segment_bank;

    localparam int DIGITS    = 4;
    localparam int BIN_W     = 14;
    localparam int BLINK_DIV = 4;
    localparam int SW        = 7 * DIGITS;

    logic              clk = 1'b0;
    logic              rst, load, hex_mode, blank_lz;
    logic [BIN_W-1:0]  value;
    logic [DIGITS-1:0] blink_en;
    logic [SW-1:0]     seg;
    logic              busy, done, overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_val = 0;
    bit m_hex = 0;

    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seven_segment_bank #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .ACTIVE_LOW(1), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .busy(busy),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; drives the blink-phase model.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic bit phase_now();
        return (cyc == 0) || ((((cyc - 1) / BLINK_DIV) % 2) == 0);
    endfunction

    function automatic logic [SW-1:0] ref_seg(int v, bit hx, bit bl, logic [DIGITS-1:0] be, bit ph);
        int dig [DIGITS];
        int d, hi;
        bit ovf;
        logic [6:0] p;
        logic [SW-1:0] r;
        ovf = !hx && (v >= 10 ** DIGITS);
        d = v;
        hi = 0;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (hx) dig[i] = (v >> (4 * i)) & 15;
            else begin dig[i] = d % 10; d = d / 10; end
            if (dig[i] != 0) hi = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)                p = 7'b0000001;
            else if (be[i] && !ph)  p = 7'b0000000;
            else if (bl && i > hi)  p = 7'b0000000;
            else                    p = glyph_tab[dig[i]];
            r[7*i +: 7] = ~p;
        end
        return r;
    endfunction

    task automatic start_load(input int v, input bit hx);
        @(negedge clk);
        value    = BIN_W'(v);
        hex_mode = hx;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert_and_check(input int v, input bit hx, input string tag);
        int lat;
        int exp_lat;
        logic [SW-1:0] exp;
        exp_lat = hx ? 1 : BIN_W + 1;
        start_load(v, hx);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_load: got %b want 1", tag, busy); end
        wait_done(lat);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s done_latency: got %0d want %0d", tag, lat, exp_lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy); end
        exp = ref_seg(m_val, m_hex, blank_lz, blink_en, phase_now());
        total++; if (seg !== exp) begin bad++; $display("FAIL %s seg_held_before_commit: got %h want %h", tag, seg, exp); end
        m_val = v;
        m_hex = hx;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_one_cycle: got %b want 0", tag, done); end
        total++; if (overflow !== (!hx && v >= 10 ** DIGITS)) begin bad++; $display("FAIL %s overflow: got %b want %b", tag, overflow, (!hx && v >= 10 ** DIGITS)); end
        exp = ref_seg(m_val, m_hex, blank_lz, blink_en, phase_now());
        total++; if (seg !== exp) begin bad++; $display("FAIL %s seg: got %h want %h", tag, seg, exp); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (seg !== {DIGITS{7'h01}}) begin bad++; $display("FAIL reset_seg: got %h want %h", seg, {DIGITS{7'h01}}); end
        total++; if ({busy, done, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); end
        blank_lz = 1'b1;
        @(negedge clk);
        total++; if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h01}) begin bad++; $display("FAIL reset_seg_lz: got %h want %h", seg, {7'h7F, 7'h7F, 7'h7F, 7'h01}); end
        blank_lz = 1'b0;
        rst = 1'b0;
        m_val = 0;
        m_hex = 0;
        @(negedge clk);
    endtask

    task automatic test_decimal();
        convert_and_check(1234, 0, "dec1234");
        total++; if (seg !== {7'h4F, 7'h12, 7'h06, 7'h4C}) begin bad++; $display("FAIL dec1234_vector: got %h want %h", seg, {7'h4F, 7'h12, 7'h06, 7'h4C}); end
    endtask

    task automatic test_hex();
        convert_and_check(16'h2BEF, 1, "hex2BEF");
        total++; if (seg !== {7'h12, 7'h60, 7'h30, 7'h38}) begin bad++; $display("FAIL hex2BEF_vector: got %h want %h", seg, {7'h12, 7'h60, 7'h30, 7'h38}); end
    endtask

    task automatic test_overflow();
        convert_and_check(10000, 0, "ovf10000");
        total++; if (seg !== {DIGITS{7'h7E}}) begin bad++; $display("FAIL ovf10000_vector: got %h want %h", seg, {DIGITS{7'h7E}}); end
        convert_and_check(9999, 0, "dec9999");
        total++; if (seg !== {DIGITS{7'h04}}) begin bad++; $display("FAIL dec9999_vector: got %h want %h", seg, {DIGITS{7'h04}}); end
    endtask

    task automatic test_leading_zero();
        @(negedge clk);
        blank_lz = 1'b1;
        convert_and_check(7, 0, "lz7");
        total++; if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h0F}) begin bad++; $display("FAIL lz7_vector: got %h want %h", seg, {7'h7F, 7'h7F, 7'h7F, 7'h0F}); end
        blank_lz = 1'b0;
        @(negedge clk);
        total++; if (seg !== {7'h01, 7'h01, 7'h01, 7'h0F}) begin bad++; $display("FAIL lz_off_vector: got %h want %h", seg, {7'h01, 7'h01, 7'h01, 7'h0F}); end
        blank_lz = 1'b1;
        convert_and_check(0, 0, "lz0");
        total++; if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h01}) begin bad++; $display("FAIL lz0_vector: got %h want %h", seg, {7'h7F, 7'h7F, 7'h7F, 7'h01}); end
        blank_lz = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_blink();
        int n_on, n_off;
        logic [SW-1:0] exp;
        n_on = 0;
        n_off = 0;
        convert_and_check(1234, 0, "blink_load");
        blink_en = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp = ref_seg(m_val, m_hex, blank_lz, blink_en, phase_now());
            total++; if (seg !== exp) begin bad++; $display("FAIL blink_cycle%0d: got %h want %h", k, seg, exp); end
            if (seg[6:0] === 7'h4C) n_on++;
            if (seg[6:0] === 7'h7F) n_off++;
        end
        total++; if (n_on != 8 || n_off != 8) begin bad++; $display("FAIL blink_duty: got on=%0d off=%0d want on=8 off=8", n_on, n_off); end
        blink_en = '0;
        @(negedge clk);
    endtask

    task automatic test_ignore_load();
        int lat;
        logic [SW-1:0] exp;
        start_load(1234, 0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5)  begin value = 14'd42; hex_mode = 1'b1; load = 1'b1; end
            if (lat == 6)  load = 1'b0;
            if (lat == 14) begin value = 14'd77; load = 1'b1; end
            if (lat == 15) load = 1'b0;
        end
        load = 1'b0;
        total++; if (lat !== BIN_W + 1) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, BIN_W + 1); end
        m_val = 1234;
        m_hex = 0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_commit_load: got busy=%b want 0", busy); end
        exp = ref_seg(m_val, m_hex, blank_lz, blink_en, phase_now());
        total++; if (seg !== exp) begin bad++; $display("FAIL ignore_seg: got %h want %h", seg, exp); end
    endtask

    task automatic test_reset_mid_shift();
        int n_done;
        logic [SW-1:0] exp;
        n_done = 0;
        start_load(5555, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_flags: got %b want 00", {busy, done}); end
        total++; if (seg !== {DIGITS{7'h01}}) begin bad++; $display("FAIL midrst_seg: got %h want %h", seg, {DIGITS{7'h01}}); end
        rst = 1'b0;
        m_val = 0;
        m_hex = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        total++; if (n_done != 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_done); end
        exp = ref_seg(m_val, m_hex, blank_lz, blink_en, phase_now());
        total++; if (seg !== exp) begin bad++; $display("FAIL midrst_seg_after: got %h want %h", seg, exp); end
    endtask

    task automatic test_back_to_back();
        convert_and_check(100, 0, "b2b_a");
        convert_and_check(16'h00A0, 1, "b2b_b");
        convert_and_check(10, 0, "b2b_c");
    endtask

    task automatic test_random();
        int v;
        bit hx;
        for (int k = 0; k < 20; k++) begin
            v  = int'($urandom_range(0, (1 << BIN_W) - 1));
            hx = bit'($urandom_range(0, 1));
            @(negedge clk);
            blank_lz = 1'($urandom_range(0, 1));
            convert_and_check(v, hx, $sformatf("rand%0d_v%0d_h%0d", k, v, hx));
        end
        blank_lz = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        blink_en = '0;
        test_reset();
        test_decimal();
        test_hex();
        test_overflow();
        test_leading_zero();
        test_blink();
        test_ignore_load();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
